isdu: RTL and testbench
=======================

ISDU -- requirements
Module: isdu

Interface
REQ-001 Parameter MEM_WAIT, default 2: cycles each memory access state holds before advancing; legal range 1..7.
REQ-002 Clk  input  1  rising-edge system clock; the only clock.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Run  input  1  start request, sampled only in HALTED.
REQ-005 Continue  input  1  resume request, sampled only in the PAUSE states.
REQ-006 Opcode  input  4  IR[15:12].
REQ-007 IR_5  input  1  immediate select for ADD/AND.
REQ-008 IR_11  input  1  JSR/JSRR select.
REQ-009 BEN  input  1  registered branch enable from the branch unit.
REQ-010 LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC  output  1 each  register load enables.
REQ-011 GatePC, GateMDR, GateALU, GateMARMUX  output  1 each  bus drivers; at most one high per cycle.
REQ-012 PCMUX  output  2  00 PC+1, 01 bus, 10 adder.
REQ-013 DRMUX, SR1MUX, SR2MUX, ADDR1MUX  output  1 each  datapath selects.
REQ-014 ADDR2MUX  output  2  00 zero, 01 off6, 10 off9, 11 off11.
REQ-015 ALUK  output  2  00 ADD, 01 AND, 10 NOT, 11 PASSA.
REQ-016 Mem_OE, Mem_WE  output  1 each  active-high memory read/write strobes; never both high.

Function
REQ-017 Moore FSM; every output SHALL be a pure decode of current state; unlisted outputs default 0.
REQ-018 States: HALTED, S18, S33, S35, PAUSE1, PAUSE2, S32, S01, S05, S09, S00, S22, S12, S04, S21, S20, S06, S25, S27, S07, S23, S16.
REQ-019 HALTED: Run=1 -> S18, else hold.
REQ-020 S18: LD_MAR, GatePC, LD_PC, PCMUX=00; -> S33.
REQ-021 S33: Mem_OE, LD_MDR; hold until wait counter reaches MEM_WAIT-1, then -> S35.
REQ-022 S35: GateMDR, LD_IR; -> S32.
REQ-023 S32: LD_BEN; decode: 0001->S01, 0101->S05, 1001->S09, 0000->S00, 1100->S12, 0100->S04, 0110->S06, 0111->S07, 1101->PAUSE1, any other opcode -> S18.
REQ-024 S01/S05/S09: GateALU, LD_REG, LD_CC, SR2MUX=IR_5, ALUK 00/01/10 respectively; -> S18.
REQ-025 S00: BEN=1 -> S22, else -> S18; BEN sampled in S00 (one cycle after S32 load).
REQ-026 S22: LD_PC, PCMUX=10, ADDR1MUX=PC, ADDR2MUX=10; -> S18.
REQ-027 S12: LD_PC, PCMUX=10, ADDR1MUX=BaseR, ADDR2MUX=00; -> S18.
REQ-028 S04: GatePC, LD_REG, DRMUX=R7; IR_11=1 -> S21, else -> S20.
REQ-029 S21: PC<-PC+off11 (PCMUX=10, ADDR2MUX=11); S20: PC<-BaseR (ADDR2MUX=00); both -> S18.
REQ-030 S06/S07: GateMARMUX, LD_MAR, ADDR1MUX=BaseR, ADDR2MUX=01; S06 -> S25, S07 -> S23.
REQ-031 S25: as S33, exits to S27; S27: GateMDR, LD_REG, LD_CC; -> S18.
REQ-032 S23: SR1MUX=IR[11:9], ALUK=11, GateALU, LD_MDR; -> S16.
REQ-033 S16: Mem_WE held MEM_WAIT cycles; then -> S18.
REQ-034 Wait counter SHALL clear on entry to S33/S25/S16 and count only in those states; MEM_WAIT=1 gives single-cycle occupancy.
REQ-035 PAUSE1: Continue=1 -> PAUSE2; PAUSE2: Continue=0 -> S18 (full press-release required).

Reset
REQ-036 Reset=1 at a rising edge SHALL force HALTED and counter 0 regardless of state, including mid-S16 or mid-S33; all outputs 0 the following cycle.
REQ-037 Reset SHALL dominate Run and Continue when asserted in the same cycle.

Structure
REQ-038 State enum, opcode constants, PCMUX/ADDR2MUX/ALUK encodings SHALL live in isdu_pkg.
REQ-039 Wait counter SHALL be sub-module isdu_wait_ctr (clear, enable, done).

Verification
REQ-040 Reset, Run=1, Opcode=0001, IR_5=1 -> HALTED,S18,S33x2,S35,S32,S01,S18; LD_REG and LD_CC high exactly in S01.
REQ-041 Opcode=0000, BEN=1 in S00 -> S22 with PCMUX=10, ADDR2MUX=10; BEN=0 -> direct S18, LD_PC never high.
REQ-042 Opcode=0111, MEM_WAIT=3 -> Mem_WE high exactly 3 consecutive cycles, Mem_OE 0 throughout.
REQ-043 Opcode=1101, Continue held 1 for 5 cycles -> stays PAUSE2 until Continue=0, then S18.
REQ-044 Reset asserted during second S16 cycle -> next cycle HALTED, Mem_WE=0; Run ignored in that Reset cycle.
REQ-045 Opcode=1010 (unsupported) -> S32 then S18, no LD_REG/LD_PC/Mem_WE assertion.

Source files
------------

// File: rtl/isdu_pkg.sv
// Shared types for the instruction sequencing and decode unit: state encoding,
// opcode constants, mux encodings and the per-state control decode.
package isdu_pkg;

  typedef enum logic [4:0] {
    HALTED, S18, S33, S35, PAUSE1, PAUSE2, S32, S01, S05, S09, S00,
    S22, S12, S04, S21, S20, S06, S25, S27, S07, S23, S16
  } isdu_state_e;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_PSE = 4'b1101;

  localparam logic [1:0] PCMUX_INC   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  localparam logic ADDR1_PC    = 1'b0;
  localparam logic ADDR1_BASER = 1'b1;
  localparam logic DR_R7       = 1'b1;
  localparam logic SR1_IR11_9  = 1'b1;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_ben;
    logic       ld_cc;
    logic       ld_reg;
    logic       ld_pc;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic [1:0] pcmux;
    logic       drmux;
    logic       sr1mux;
    logic       sr2_ir;   // SR2MUX follows IR_5 in this state
    logic       addr1mux;
    logic [1:0] addr2mux;
    logic [1:0] aluk;
    logic       mem_oe;
    logic       mem_we;
  } isdu_ctrl_t;

  function automatic isdu_ctrl_t isdu_decode(isdu_state_e s);
    isdu_ctrl_t c;
    c = '0;
    case (s)
      S18: begin c.ld_mar = 1'b1; c.gate_pc = 1'b1; c.ld_pc = 1'b1; c.pcmux = PCMUX_INC; end
      S33, S25: begin c.mem_oe = 1'b1; c.ld_mdr = 1'b1; end
      S35: begin c.gate_mdr = 1'b1; c.ld_ir = 1'b1; end
      S32: c.ld_ben = 1'b1;
      S01, S05, S09: begin
        c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; c.sr2_ir = 1'b1;
        c.aluk = (s == S01) ? ALUK_ADD : (s == S05) ? ALUK_AND : ALUK_NOT;
      end
      S22: begin
        c.ld_pc = 1'b1; c.pcmux = PCMUX_ADDER; c.addr1mux = ADDR1_PC; c.addr2mux = ADDR2_OFF9;
      end
      S12, S20: begin
        c.ld_pc = 1'b1; c.pcmux = PCMUX_ADDER; c.addr1mux = ADDR1_BASER; c.addr2mux = ADDR2_ZERO;
      end
      S04: begin c.gate_pc = 1'b1; c.ld_reg = 1'b1; c.drmux = DR_R7; end
      S21: begin
        c.ld_pc = 1'b1; c.pcmux = PCMUX_ADDER; c.addr1mux = ADDR1_PC; c.addr2mux = ADDR2_OFF11;
      end
      S06, S07: begin
        c.gate_marmux = 1'b1; c.ld_mar = 1'b1; c.addr1mux = ADDR1_BASER; c.addr2mux = ADDR2_OFF6;
      end
      S27: begin c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; end
      S23: begin
        c.sr1mux = SR1_IR11_9; c.aluk = ALUK_PASSA; c.gate_alu = 1'b1; c.ld_mdr = 1'b1;
      end
      S16: c.mem_we = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/isdu_wait_ctr.sv
// Memory wait counter: counts occupancy cycles of a memory state and flags the last one.
module isdu_wait_ctr #(
  parameter int MEM_WAIT = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  logic [2:0] cnt;

  always_ff @(posedge Clk) begin
    if (Reset || clear) cnt <= '0;
    else if (enable)    cnt <= cnt + 3'd1;
  end

  assign done = enable && (cnt == 3'(MEM_WAIT - 1));

endmodule

// File: rtl/isdu.sv
// Instruction sequencing and decode unit: Moore control FSM for a small LC-3 style
// datapath. Control outputs are registered from the decode of the next state.
module isdu
  import isdu_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic        Continue,
  input  logic [3:0]  Opcode,
  input  logic        IR_5,
  input  logic        IR_11,
  input  logic        BEN,
  output logic        LD_MAR,
  output logic        LD_MDR,
  output logic        LD_IR,
  output logic        LD_BEN,
  output logic        LD_CC,
  output logic        LD_REG,
  output logic        LD_PC,
  output logic        GatePC,
  output logic        GateMDR,
  output logic        GateALU,
  output logic        GateMARMUX,
  output logic [1:0]  PCMUX,
  output logic        DRMUX,
  output logic        SR1MUX,
  output logic        SR2MUX,
  output logic        ADDR1MUX,
  output logic [1:0]  ADDR2MUX,
  output logic [1:0]  ALUK,
  output logic        Mem_OE,
  output logic        Mem_WE,
  output isdu_state_e dbg_state
);

  isdu_state_e state, state_n;
  isdu_ctrl_t  ctrl_q;
  logic        in_wait, wait_done;

  assign in_wait = (state == S33) || (state == S25) || (state == S16);

  // Counter sits at zero outside the memory states so every entry starts fresh.
  isdu_wait_ctr #(.MEM_WAIT(MEM_WAIT)) u_wait_ctr (
    .Clk    (Clk),
    .Reset  (Reset),
    .clear  (!in_wait || wait_done),
    .enable (in_wait),
    .done   (wait_done)
  );

  always_comb begin
    state_n = state;
    case (state)
      HALTED: if (Run) state_n = S18;
      S18:    state_n = S33;
      S33:    if (wait_done) state_n = S35;
      S35:    state_n = S32;
      S32: begin
        case (Opcode)
          OP_ADD:  state_n = S01;
          OP_AND:  state_n = S05;
          OP_NOT:  state_n = S09;
          OP_BR:   state_n = S00;
          OP_JMP:  state_n = S12;
          OP_JSR:  state_n = S04;
          OP_LDR:  state_n = S06;
          OP_STR:  state_n = S07;
          OP_PSE:  state_n = PAUSE1;
          default: state_n = S18;
        endcase
      end
      S00:    state_n = BEN ? S22 : S18;
      S04:    state_n = IR_11 ? S21 : S20;
      S06:    state_n = S25;
      S25:    if (wait_done) state_n = S27;
      S07:    state_n = S23;
      S23:    state_n = S16;
      S16:    if (wait_done) state_n = S18;
      PAUSE1: if (Continue) state_n = PAUSE2;
      PAUSE2: if (!Continue) state_n = S18;
      S01, S05, S09, S22, S12, S21, S20, S27: state_n = S18;
      default: state_n = HALTED;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= HALTED;
      ctrl_q <= '0;
    end else begin
      state  <= state_n;
      ctrl_q <= isdu_decode(state_n);
    end
  end

  assign LD_MAR     = ctrl_q.ld_mar;
  assign LD_MDR     = ctrl_q.ld_mdr;
  assign LD_IR      = ctrl_q.ld_ir;
  assign LD_BEN     = ctrl_q.ld_ben;
  assign LD_CC      = ctrl_q.ld_cc;
  assign LD_REG     = ctrl_q.ld_reg;
  assign LD_PC      = ctrl_q.ld_pc;
  assign GatePC     = ctrl_q.gate_pc;
  assign GateMDR    = ctrl_q.gate_mdr;
  assign GateALU    = ctrl_q.gate_alu;
  assign GateMARMUX = ctrl_q.gate_marmux;
  assign PCMUX      = ctrl_q.pcmux;
  assign DRMUX      = ctrl_q.drmux;
  assign SR1MUX     = ctrl_q.sr1mux;
  assign SR2MUX     = ctrl_q.sr2_ir & IR_5;
  assign ADDR1MUX   = ctrl_q.addr1mux;
  assign ADDR2MUX   = ctrl_q.addr2mux;
  assign ALUK       = ctrl_q.aluk;
  assign Mem_OE     = ctrl_q.mem_oe;
  assign Mem_WE     = ctrl_q.mem_we;
  assign dbg_state  = state;

endmodule

// File: tb/tb_isdu.sv
// Bench for isdu: three instances (MEM_WAIT 1..3) exercised one at a time against an
// instruction-level trace model that expands each instruction into its expected states.
module tb_isdu;
  import isdu_pkg::*;

  logic        clk;
  logic [2:0]  rst;
  logic        run, cont, ir_5, ir_11, ben;
  logic [3:0]  opcode;
  logic [22:0] obs [3];
  isdu_state_e st_obs [3];

  int total = 0;
  int bad   = 0;
  int cur   = 0;

  // Expected trace entry: {state[4:0], Continue, BEN, Run} driven/checked per cycle.
  logic [7:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux, addr2mux, aluk;
    logic drmux, sr1mux, sr2mux, addr1mux, mem_oe, mem_we;
    isdu_state_e dbg;

    isdu #(.MEM_WAIT(k + 1)) u_dut (
      .Clk(clk), .Reset(rst[k]), .Run(run), .Continue(cont), .Opcode(opcode),
      .IR_5(ir_5), .IR_11(ir_11), .BEN(ben),
      .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .LD_IR(ld_ir), .LD_BEN(ld_ben), .LD_CC(ld_cc),
      .LD_REG(ld_reg), .LD_PC(ld_pc), .GatePC(gate_pc), .GateMDR(gate_mdr),
      .GateALU(gate_alu), .GateMARMUX(gate_marmux), .PCMUX(pcmux), .DRMUX(drmux),
      .SR1MUX(sr1mux), .SR2MUX(sr2mux), .ADDR1MUX(addr1mux), .ADDR2MUX(addr2mux),
      .ALUK(aluk), .Mem_OE(mem_oe), .Mem_WE(mem_we), .dbg_state(dbg)
    );

    assign obs[k] = {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc,
                     gate_pc, gate_mdr, gate_alu, gate_marmux, pcmux,
                     drmux, sr1mux, sr2mux, addr1mux, addr2mux, aluk, mem_oe, mem_we};
    assign st_obs[k] = dbg;
  end

  // Control word each state must present, written straight from the state descriptions.
  function automatic logic [22:0] exp_out(isdu_state_e s, logic ir5);
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc;
    logic g_pc, g_mdr, g_alu, g_marmux, drmux, sr1mux, sr2mux, addr1mux, oe, we;
    logic [1:0] pcmux, addr2mux, aluk;
    {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc} = '0;
    {g_pc, g_mdr, g_alu, g_marmux, drmux, sr1mux, sr2mux, addr1mux, oe, we} = '0;
    pcmux = 2'b00; addr2mux = 2'b00; aluk = 2'b00;
    if (s == S18) begin ld_mar = 1; g_pc = 1; ld_pc = 1; end
    if (s == S33 || s == S25) begin oe = 1; ld_mdr = 1; end
    if (s == S35) begin g_mdr = 1; ld_ir = 1; end
    if (s == S32) ld_ben = 1;
    if (s == S01 || s == S05 || s == S09) begin
      g_alu = 1; ld_reg = 1; ld_cc = 1; sr2mux = ir5;
      aluk = (s == S01) ? 2'd0 : (s == S05) ? 2'd1 : 2'd2;
    end
    if (s == S22) begin ld_pc = 1; pcmux = 2'b10; addr2mux = 2'b10; end
    if (s == S12 || s == S20) begin ld_pc = 1; pcmux = 2'b10; addr1mux = 1; end
    if (s == S21) begin ld_pc = 1; pcmux = 2'b10; addr2mux = 2'b11; end
    if (s == S04) begin g_pc = 1; ld_reg = 1; drmux = 1; end
    if (s == S06 || s == S07) begin g_marmux = 1; ld_mar = 1; addr1mux = 1; addr2mux = 2'b01; end
    if (s == S27) begin g_mdr = 1; ld_reg = 1; ld_cc = 1; end
    if (s == S23) begin sr1mux = 1; aluk = 2'b11; g_alu = 1; ld_mdr = 1; end
    if (s == S16) we = 1;
    return {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, g_pc, g_mdr, g_alu, g_marmux,
            pcmux, drmux, sr1mux, sr2mux, addr1mux, addr2mux, aluk, oe, we};
  endfunction

  task automatic push(isdu_state_e s, logic c, logic b, logic r);
    exp_q.push_back({s, c, b, r});
  endtask

  // Inputs that the state ignores are randomised so stray sampling shows up.
  task automatic push_any(isdu_state_e s);
    push(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic build(logic [3:0] op, logic i11, logic b, int w, int pa, int pb);
    push_any(S18);
    repeat (w) push_any(S33);
    push_any(S35);
    push_any(S32);
    case (op)
      OP_ADD: push_any(S01);
      OP_AND: push_any(S05);
      OP_NOT: push_any(S09);
      OP_BR: begin
        push(S00, 1'($urandom_range(0, 1)), b, 1'($urandom_range(0, 1)));
        if (b) push_any(S22);
      end
      OP_JMP: push_any(S12);
      OP_JSR: begin push_any(S04); push_any(i11 ? S21 : S20); end
      OP_LDR: begin push_any(S06); repeat (w) push_any(S25); push_any(S27); end
      OP_STR: begin push_any(S07); push_any(S23); repeat (w) push_any(S16); end
      OP_PSE: begin
        repeat (pa) push(PAUSE1, 1'b0, 1'b0, 1'b1);
        push(PAUSE1, 1'b1, 1'b0, 1'b0);
        repeat (pb) push(PAUSE2, 1'b1, 1'b1, 1'b1);
        push(PAUSE2, 1'b0, 1'b0, 1'b1);
      end
      default: ;
    endcase
  endtask

  task automatic check_now(string tag, isdu_state_e st, logic ir5);
    isdu_state_e so;
    logic [22:0] ev, ov;
    so = st_obs[cur];
    ov = obs[cur];
    ev = exp_out(st, ir5);
    total++;
    assert (so === st) else begin
      bad++;
      $error("FAIL %s_state inst=%0d obs=%s exp=%s", tag, cur, so.name(), st.name());
    end
    total++;
    assert (ov === ev) else begin
      bad++;
      $error("FAIL %s_ctrl inst=%0d state=%s obs=%h exp=%h", tag, cur, st.name(), ov, ev);
    end
  endtask

  task automatic run_trace(string tag, int cut, output int we_n, output int oe_n);
    int n;
    logic [7:0] e;
    n = 0; we_n = 0; oe_n = 0;
    while (exp_q.size() > 0 && (cut < 0 || n < cut)) begin
      e = exp_q.pop_front();
      cont = e[2]; ben = e[1]; run = e[0];
      check_now(tag, isdu_state_e'(e[7:3]), ir_5);
      if (obs[cur][0]) we_n++;
      if (obs[cur][1]) oe_n++;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_instr(logic [3:0] op, logic i5, logic i11, logic b, int pa, int pb);
    int w, we_n, oe_n;
    w = cur + 1;
    opcode = op; ir_5 = i5; ir_11 = i11;
    build(op, i11, b, w, pa, pb);
    run_trace($sformatf("op%h", op), -1, we_n, oe_n);
    total++;
    assert (we_n === ((op == OP_STR) ? w : 0)) else begin
      bad++; $error("FAIL we_cycles op=%h obs=%0d exp=%0d", op, we_n, (op == OP_STR) ? w : 0);
    end
    total++;
    assert (oe_n === ((op == OP_LDR) ? 2 * w : w)) else begin
      bad++; $error("FAIL oe_cycles op=%h obs=%0d exp=%0d", op, oe_n, (op == OP_LDR) ? 2 * w : w);
    end
  endtask

  task automatic start();
    rst = '1; run = 1'b1; cont = 1'b1;
    @(negedge clk);
    check_now("rst_dominates_run", HALTED, 1'b0);
    rst[cur] = 1'b0; run = 1'b0;
    @(negedge clk);
    check_now("halted_hold", HALTED, 1'b0);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  // Reset lands on the cycle after `cut` trace entries, mid memory access.
  task automatic reset_mid(logic [3:0] op, int cut);
    int a, b2;
    logic [7:0] e;
    opcode = op; ir_5 = 1'b0; ir_11 = 1'b0;
    build(op, 1'b0, 1'b0, cur + 1, 0, 0);
    run_trace("pre_rst", cut, a, b2);
    e = exp_q.pop_front();
    rst[cur] = 1'b1; run = 1'b1; cont = 1'b1;
    check_now("mid_rst", isdu_state_e'(e[7:3]), 1'b0);
    @(negedge clk);
    check_now("post_rst", HALTED, 1'b0);
    exp_q.delete();
    rst[cur] = 1'b0; run = 1'b0;
    @(negedge clk);
    check_now("post_rst_idle", HALTED, 1'b0);
  endtask

  initial begin
    rst = '1; run = 0; cont = 0; ben = 0; ir_5 = 0; ir_11 = 0; opcode = 4'h0;
    for (int k = 0; k < 3; k++) begin
      cur = k;
      start();
      do_instr(OP_ADD, 1'b1, 1'b0, 1'b0, 0, 0);
      do_instr(OP_AND, 1'b0, 1'b0, 1'b0, 0, 0);
      do_instr(OP_NOT, 1'b1, 1'b0, 1'b0, 0, 0);
      do_instr(OP_BR, 1'b0, 1'b0, 1'b1, 0, 0);
      do_instr(OP_BR, 1'b0, 1'b0, 1'b0, 0, 0);
      do_instr(OP_STR, 1'b0, 1'b0, 1'b0, 0, 0);
      do_instr(OP_LDR, 1'b0, 1'b0, 1'b0, 0, 0);
      do_instr(OP_PSE, 1'b0, 1'b0, 1'b0, 2, 4);
      do_instr(4'b1010, 1'b1, 1'b1, 1'b1, 0, 0);
      do_instr(OP_JSR, 1'b0, 1'b1, 1'b0, 0, 0);
      do_instr(OP_JSR, 1'b0, 1'b0, 1'b0, 0, 0);
      do_instr(OP_JMP, 1'b0, 1'b0, 1'b0, 0, 0);
      for (int i = 0; i < 30; i++) begin
        do_instr(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
      end
      if (k >= 1) begin
        reset_mid(OP_STR, k + 7);
        start();
        reset_mid(OP_ADD, 2);
        start();
        do_instr(OP_LDR, 1'b0, 1'b0, 1'b0, 0, 0);
      end
      rst = '1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
